// File: rtl/id_bypass_pkg.sv
// Shared types for the decode-stage bypass slot: forwarding-source record and source indices.
package id_bypass_pkg;
    localparam int FW_AW_MAX   = 8;
    localparam int FW_XLEN_MAX = 64;

    localparam int FW_EXE = 0;
    localparam int FW_MEM = 1;
    localparam int FW_WB  = 2;

    // Fields are sized for the widest configuration; narrower builds zero-extend.
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [FW_AW_MAX-1:0]   addr;
        logic [FW_XLEN_MAX-1:0] data;
        logic                   ready;
    } fw_src_t;
endpackage

// File: rtl/id_operand_resolve.sv
// One operand port: youngest-first source match, hazard detect, and back-pressure capture register.
module id_operand_resolve
    import id_bypass_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NSRC     = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic                 need,
    input  logic [AW-1:0]        addr,
    input  logic [XLEN-1:0]      rf_data,
    input  fw_src_t [NSRC-1:0]   src,
    input  logic                 cap_clr,
    input  logic                 cap_set,
    output logic [XLEN-1:0]      rd_data,
    output logic                 hazard
);
    logic                   is_zero;
    logic                   active;
    logic                   hit;
    logic                   hit_rdy;
    logic [FW_XLEN_MAX-1:0] hit_data;
    logic [XLEN-1:0]        resolved;
    logic                   cap;
    logic [XLEN-1:0]        cap_data;

    assign is_zero = ZERO_REG && (addr == '0);
    assign active  = valid & need & ~is_zero;

    // Scan oldest to youngest so the youngest match overwrites: an older ready
    // source can never hide a younger one that is still pending.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int s = NSRC - 1; s >= 0; s--) begin
            if (src[s].valid && src[s].we && src[s].addr == FW_AW_MAX'(addr)) begin
                hit      = 1'b1;
                hit_rdy  = src[s].ready;
                hit_data = src[s].data;
            end
        end
    end

    always_comb begin
        resolved = rf_data;
        if (is_zero)
            resolved = '0;
        else if (active && hit)
            resolved = hit_data[XLEN-1:0];
    end

    assign hazard  = active & hit & ~hit_rdy & ~cap;
    assign rd_data = cap ? cap_data : resolved;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap      <= 1'b0;
            cap_data <= '0;
        end else if (cap_clr) begin
            cap      <= 1'b0;
        end else if (cap_set && active && !cap) begin
            cap      <= 1'b1;
            cap_data <= resolved;
        end
    end
endmodule

// File: rtl/id_bypass_stage.sv
// Decode pipeline slot: holds one payload, resolves NRD operands against NSRC in-flight writers.
module id_bypass_stage
    import id_bypass_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int NSRC      = 3,
    parameter int PAYLOAD_W = 64,
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_allowin,
    input  logic [PAYLOAD_W-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PAYLOAD_W-1:0]  out_data,
    input  logic                  flush,
    input  logic                  cancel_req,
    output logic                  cancel,
    input  logic [NRD-1:0]        rd_need,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic [NRD*XLEN-1:0]   rf_data,
    input  logic [NSRC-1:0]       fw_valid,
    input  logic [NSRC-1:0]       fw_we,
    input  logic [NSRC*AW-1:0]    fw_addr,
    input  logic [NSRC*XLEN-1:0]  fw_data,
    input  logic [NSRC-1:0]       fw_ready,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic                  ready_go,
    output logic [31:0]           stall_cnt
);
    logic                 valid;
    logic                 valid_nxt;
    logic                 load;
    logic                 cap_clr;
    logic                 cap_set;
    logic [NRD-1:0]       hazard;
    fw_src_t [NSRC-1:0]   src;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign src[s] = '{valid: fw_valid[s],
                          we:    fw_we[s],
                          addr:  FW_AW_MAX'(fw_addr[s*AW +: AW]),
                          data:  FW_XLEN_MAX'(fw_data[s*XLEN +: XLEN]),
                          ready: fw_ready[s]};
    end

    assign ready_go   = ~|hazard;
    assign out_valid  = valid & ready_go;
    assign in_allowin = ~valid | (ready_go & out_ready);
    assign cancel     = valid & cancel_req & ready_go & out_ready;
    assign load       = in_allowin & in_valid;

    always_comb begin
        valid_nxt = valid;
        if (flush || cancel)
            valid_nxt = 1'b0;
        else if (in_allowin)
            valid_nxt = in_valid;
    end

    // Freeze operands only while the instruction is ready but EXE is stalling.
    assign cap_set = valid & ready_go & ~out_ready;
    assign cap_clr = flush | load | ~valid_nxt;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        id_operand_resolve #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NSRC     (NSRC),
            .ZERO_REG (ZERO_REG)
        ) u_res (
            .clk      (clk),
            .reset    (reset),
            .valid    (valid),
            .need     (rd_need[p]),
            .addr     (rd_addr[p*AW +: AW]),
            .rf_data  (rf_data[p*XLEN +: XLEN]),
            .src      (src),
            .cap_clr  (cap_clr),
            .cap_set  (cap_set),
            .rd_data  (rd_data[p*XLEN +: XLEN]),
            .hazard   (hazard[p])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            out_data  <= '0;
            stall_cnt <= '0;
        end else begin
            valid <= valid_nxt;
            if (load)
                out_data <= in_data;
            if (valid && !ready_go && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_id_bypass_stage.sv
// Directed bench for id_bypass_stage: stall, priority, zero reg, capture, cancel, flush, reset.
module tb_id_bypass_stage;
    localparam int XLEN = 32, AW = 5, NRD = 2, NSRC = 3, PW = 64;

    logic              clk = 1'b0;
    logic              reset, in_valid, in_allowin, out_valid, out_ready;
    logic              flush, cancel_req, cancel, ready_go;
    logic [PW-1:0]     in_data, out_data;
    logic [NRD-1:0]    rd_need;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*XLEN-1:0] rf_data, rd_data;
    logic [NSRC-1:0]   fw_valid, fw_we, fw_ready;
    logic [NSRC*AW-1:0]   fw_addr;
    logic [NSRC*XLEN-1:0] fw_data;
    logic [31:0]       stall_cnt;

    int checks = 0;
    int errors = 0;

    id_bypass_stage #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NSRC(NSRC), .PAYLOAD_W(PW), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_allowin(in_allowin), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
        .cancel_req(cancel_req), .cancel(cancel), .rd_need(rd_need), .rd_addr(rd_addr),
        .rf_data(rf_data), .fw_valid(fw_valid), .fw_we(fw_we), .fw_addr(fw_addr),
        .fw_data(fw_data), .fw_ready(fw_ready), .rd_data(rd_data), .ready_go(ready_go),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d, input logic r);
        fw_valid[s] = v;
        fw_we[s]    = v;
        fw_addr[s*AW +: AW]     = a;
        fw_data[s*XLEN +: XLEN] = d;
        fw_ready[s] = r;
    endtask

    task automatic clr_src();
        fw_valid = '0; fw_we = '0; fw_addr = '0; fw_data = '0; fw_ready = '0;
    endtask

    task automatic load_instr(input logic [PW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; flush = 0; cancel_req = 0;
        rd_need = '0; rd_addr = '0; rf_data = '0;
        clr_src();
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_allowin", in_allowin, 1);
        chk("rst_cancel", cancel, 0);
        chk("rst_ready_go", ready_go, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_data", out_data, 0);

        // Load-use: EXE load to r5 not ready, then reaches MEM with data.
        out_ready = 1'b1;
        load_instr(64'h1000_0000_0000_0001);
        rd_need = 2'b01; rd_addr = {5'd0, 5'd5}; rf_data = {32'h0, 32'hAAAA};
        set_src(0, 1, 5'd5, 32'h0, 0);
        #1;
        chk("lu_ready_go", ready_go, 0);
        chk("lu_out_valid", out_valid, 0);
        chk("lu_allowin", in_allowin, 0);
        chk("lu_out_data", out_data, 64'h1000_0000_0000_0001);
        tick();
        chk("lu_stall_cnt", stall_cnt, 1);
        clr_src();
        set_src(1, 1, 5'd5, 32'hDEAD, 1);
        #1;
        chk("lu_release_valid", out_valid, 1);
        chk("lu_release_data", rd_data[31:0], 32'hDEAD);
        chk("lu_release_allowin", in_allowin, 1);
        tick();
        chk("lu_drained", out_valid, 0);
        chk("lu_stall_hold", stall_cnt, 1);

        // Priority between EXE and WB, and zero register.
        clr_src();
        load_instr(64'h2000_0000_0000_0002);
        rd_addr = {5'd0, 5'd7};
        set_src(0, 1, 5'd7, 32'h11, 1);
        set_src(2, 1, 5'd7, 32'h22, 1);
        #1;
        chk("pri_exe_wins", rd_data[31:0], 32'h11);
        fw_ready[0] = 1'b0;
        #1;
        chk("pri_exe_stall", ready_go, 0);
        fw_valid[0] = 1'b0;
        #1;
        chk("pri_wb_only", rd_data[31:0], 32'h22);
        chk("pri_wb_go", ready_go, 1);
        clr_src();
        rd_need = 2'b11; rd_addr = {5'd0, 5'd0}; rf_data = {32'h66, 32'h55};
        set_src(0, 1, 5'd0, 32'hBAD, 0);
        #1;
        chk("zero_go", ready_go, 1);
        chk("zero_data0", rd_data[31:0], 0);
        chk("zero_data1", rd_data[63:32], 0);
        clr_src();
        tick();
        chk("pri_drained", out_valid, 0);

        // Capture under back-pressure.
        load_instr(64'h3000_0000_0000_0003);
        out_ready = 1'b0;
        rd_need = 2'b01; rd_addr = {5'd0, 5'd9}; rf_data = {32'h0, 32'h99};
        set_src(1, 1, 5'd9, 32'h33, 1);
        #1;
        chk("cap_first", rd_data[31:0], 32'h33);
        chk("cap_allowin", in_allowin, 0);
        tick();
        clr_src();
        tick(); tick();
        chk("cap_held", rd_data[31:0], 32'h33);
        out_ready = 1'b1;
        #1;
        chk("cap_release_data", rd_data[31:0], 32'h33);
        chk("cap_release_valid", out_valid, 1);
        tick();
        chk("cap_cleared", rd_data[31:0], 32'h99);

        // Branch cancel waits for the branch to leave.
        load_instr(64'h4000_0000_0000_0004);
        cancel_req = 1'b1; out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h5000_0000_0000_0005;
        #1;
        chk("br_no_cancel", cancel, 0);
        tick();
        chk("br_held_valid", out_valid, 1);
        chk("br_held_data", out_data, 64'h4000_0000_0000_0004);
        out_ready = 1'b1;
        #1;
        chk("br_cancel", cancel, 1);
        tick();
        chk("br_empty", out_valid, 0);
        cancel_req = 1'b0; in_valid = 1'b0;
        #1;
        chk("br_allowin", in_allowin, 1);

        // Flush with concurrent load, captured operand must be dropped.
        load_instr(64'h6000_0000_0000_0006);
        out_ready = 1'b0;
        rf_data = {32'h0, 32'h99};
        set_src(1, 1, 5'd9, 32'h44, 1);
        tick();
        clr_src();
        rf_data = {32'h0, 32'h77};
        out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 64'h7000_0000_0000_0007;
        #1;
        chk("fl_allowin", in_allowin, 1);
        chk("fl_cap_data", rd_data[31:0], 32'h44);
        tick();
        chk("fl_empty", out_valid, 0);
        flush = 1'b0;
        out_ready = 1'b0;
        load_instr(64'h8000_0000_0000_0008);
        chk("fl_reload_valid", out_valid, 1);
        chk("fl_cap_clear", rd_data[31:0], 32'h77);

        // Reset in the middle of a stall.
        out_ready = 1'b1;
        tick();
        load_instr(64'h9000_0000_0000_0009);
        set_src(0, 1, 5'd9, 32'h0, 0);
        tick(); tick();
        chk("rs_stall_cnt", stall_cnt, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_stall_zero", stall_cnt, 0);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_allowin", in_allowin, 1);
        chk("rs_out_data", out_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
